// File: rtl/queen_solver.sv
// Sequential N-queens backtracking solver streaming every board over a valid/ready port.
// Define QUEEN_FIRST_ONLY_EN to stop after the first accepted solution.
module queen_solver #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           sol_valid,
    input  logic           sol_ready,
    output logic [3*N-1:0] sol_board,
    output logic [7:0]     sol_count
);
    localparam int unsigned CW   = 3;
    localparam int unsigned BW   = 3 * N;
    localparam int unsigned MAXQ = 8;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE, CHECK, ADVANCE, BACK, EMIT, FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q [MAXQ];
    logic [CW-1:0]  col_d [MAXQ];
    logic [CW-1:0]  row_q, row_d;
    logic [CW-1:0]  k_q, k_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sol_valid_q, sol_valid_d;
    logic [BW-1:0]  sol_board_q, sol_board_d;
    logic [7:0]     sol_count_q, sol_count_d;
    logic [CW-1:0]  cand, placed;
    logic           conflict;

    // Absolute difference on zero-extended 4-bit operands.
    function automatic logic [3:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        abs_diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        k_d         = k_q;
        sol_count_d = sol_count_q;
        sol_board_d = sol_board_q;
        cand        = col_q[row_q];
        placed      = col_q[k_q];
        conflict    = (placed == cand) || (abs_diff(row_q, k_q) == abs_diff(cand, placed));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    row_d       = '0;
                    k_d         = '0;
                    col_d[0]    = '0;
                    sol_count_d = '0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (k_q == row_q) begin
                    if (row_q == LAST) begin
                        state_d = EMIT;
                    end else begin
                        row_d                  = row_q + 3'd1;
                        col_d[row_q + 3'd1]    = '0;
                        k_d                    = '0;
                    end
                end else if (conflict) begin
                    state_d = ADVANCE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ADVANCE: begin
                if (col_q[row_q] == LAST) begin
                    state_d = BACK;
                end else begin
                    col_d[row_q] = col_q[row_q] + 3'd1;
                    k_d          = '0;
                    state_d      = CHECK;
                end
            end
            BACK: begin
                if (row_q == '0) begin
                    state_d = FINISH;
                end else begin
                    row_d   = row_q - 3'd1;
                    state_d = ADVANCE;
                end
            end
            EMIT: begin
                if (sol_ready) begin
                    if (sol_count_q != 8'hFF) begin
                        sol_count_d = sol_count_q + 8'd1;
                    end
`ifdef QUEEN_FIRST_ONLY_EN
                    state_d = FINISH;
`else
                    state_d = ADVANCE;
`endif
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d == CHECK) || (state_d == ADVANCE) ||
                      (state_d == BACK)  || (state_d == EMIT);
        done_d      = (state_d == FINISH);
        sol_valid_d = (state_d == EMIT);
        // Board is captured once on entry to EMIT and held through any stall.
        if ((state_d == EMIT) && (state_q != EMIT)) begin
            for (int unsigned r = 0; r < N; r++) begin
                sol_board_d[3*r +: 3] = col_d[3'(r)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < int'(MAXQ); i++) begin
                col_q[i] <= '0;
            end
            row_q       <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sol_valid_q <= 1'b0;
            sol_board_q <= '0;
            sol_count_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sol_valid_q <= sol_valid_d;
            sol_board_q <= sol_board_d;
            sol_count_q <= sol_count_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sol_valid = sol_valid_q;
    assign sol_board = sol_board_q;
    assign sol_count = sol_count_q;

endmodule
